// File: rtl/axis_spi_reg_seq.sv
// axis_spi_reg_seq: register-access sequencer in front of a byte-wide AXI-Stream
// SPI master. One command becomes a 3-byte frame {rw/addr_hi, addr_lo, data} on
// the Tx stream; the 3 echoed Rx bytes are collected and one response
// (read data or write ack, plus timeout error) is returned per command.
module axis_spi_reg_seq #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter bit READ_FLAG      = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [14:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        busy
);
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RSP} state_t;

    state_t          state_q, state_d;
    logic [23:0]     frame_q, frame_d;      // byte0 in [23:16], byte2 in [7:0]
    logic            rw_q, rw_d;
    logic [1:0]      tx_cnt_q, tx_cnt_d;
    logic [1:0]      rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      m_axis_tdata_q, m_axis_tdata_d;
    logic            m_axis_tvalid_q, m_axis_tvalid_d;
    logic            s_axis_tready_q, s_axis_tready_d;
    logic            busy_q, busy_d;
    logic            tx_hs, rx_hs;

    // Handshakes are judged on registered ready/valid, so no input reaches an output combinationally
    assign tx_hs = m_axis_tvalid_q & m_axis_tready;
    assign rx_hs = s_axis_tvalid & s_axis_tready_q;

    // Next-state and next-output logic for the IDLE -> XFER -> RSP sequence
    always_comb begin
        state_d         = state_q;
        frame_d         = frame_q;
        rw_d            = rw_q;
        tx_cnt_d        = tx_cnt_q;
        rx_cnt_d        = rx_cnt_q;
        to_cnt_d        = to_cnt_q;
        cmd_ready_d     = cmd_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        m_axis_tvalid_d = m_axis_tvalid_q;
        m_axis_tdata_d  = m_axis_tdata_q;
        s_axis_tready_d = 1'b1;             // Rx is always drained; stray bytes are dropped
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    frame_d         = {(cmd_rw ? READ_FLAG : ~READ_FLAG), cmd_addr,
                                       (cmd_rw ? 8'h00 : cmd_wdata)};
                    rw_d            = cmd_rw;
                    tx_cnt_d        = 2'd0;
                    rx_cnt_d        = 2'd0;
                    to_cnt_d        = '0;
                    cmd_ready_d     = 1'b0;
                    m_axis_tvalid_d = 1'b1;
                    state_d         = S_XFER;
                end
            end
            S_XFER: begin
                if (tx_hs) tx_cnt_d = tx_cnt_q + 2'd1;
                if (rx_hs) rx_cnt_d = rx_cnt_q + 2'd1;
                to_cnt_d        = (tx_hs || rx_hs) ? '0 : to_cnt_q + TO_W'(1);
                // tvalid stays up until all three bytes are taken so SS stays low
                m_axis_tvalid_d = (tx_cnt_d != 2'd3);
                if (rx_hs && rx_cnt_q == 2'd2) begin
                    // third echoed byte carries the register contents on a read
                    rsp_rdata_d     = rw_q ? s_axis_tdata : 8'h00;
                    rsp_err_d       = 1'b0;
                    rsp_valid_d     = 1'b1;
                    m_axis_tvalid_d = 1'b0;
                    state_d         = S_RSP;
                end else if (!tx_hs && !rx_hs && to_cnt_q == TO_LAST) begin
                    rsp_rdata_d     = 8'h00;
                    rsp_err_d       = 1'b1;
                    rsp_valid_d     = 1'b1;
                    m_axis_tvalid_d = 1'b0;
                    state_d         = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 8'h00;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Present the byte selected by the updated Tx count; held while stalled
        if (m_axis_tvalid_d) begin
            case (tx_cnt_d)
                2'd0:    m_axis_tdata_d = frame_d[23:16];
                2'd1:    m_axis_tdata_d = frame_d[15:8];
                default: m_axis_tdata_d = frame_d[7:0];
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            frame_q         <= '0;
            rw_q            <= 1'b0;
            tx_cnt_q        <= '0;
            rx_cnt_q        <= '0;
            to_cnt_q        <= '0;
            cmd_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            m_axis_tdata_q  <= '0;
            m_axis_tvalid_q <= 1'b0;
            s_axis_tready_q <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_q         <= frame_d;
            rw_q            <= rw_d;
            tx_cnt_q        <= tx_cnt_d;
            rx_cnt_q        <= rx_cnt_d;
            to_cnt_q        <= to_cnt_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
            m_axis_tdata_q  <= m_axis_tdata_d;
            m_axis_tvalid_q <= m_axis_tvalid_d;
            s_axis_tready_q <= s_axis_tready_d;
            busy_q          <= busy_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axis_tdata  = m_axis_tdata_q;
    assign m_axis_tvalid = m_axis_tvalid_q;
    assign s_axis_tready = s_axis_tready_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_axis_spi_reg_seq.sv
// Bench for axis_spi_reg_seq: a combined SPI master/slave agent on the streams,
// a register-file scoreboard for expected responses, randomized handshake gaps.
module tb_axis_spi_reg_seq;
    localparam int TO = 16;
    localparam bit RF = 1'b1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        busy;

    always #5 aclk = ~aclk;

    axis_spi_reg_seq #(.TIMEOUT_CYCLES(TO), .READ_FLAG(RF)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .busy(busy)
    );

    typedef struct packed { logic rw; logic [14:0] addr; logic [7:0] wdata; } cmd_t;
    typedef struct packed { logic [7:0] rdata; logic err; } rsp_t;
    typedef struct packed { logic [7:0] d; logic [31:0] t; } miso_t;

    logic [7:0] slave_mem [32768];   // contents seen by the SPI slave
    logic [7:0] ref_mem   [32768];   // scoreboard copy, updated in command order
    cmd_t       cmd_q[$];
    logic [7:0] exp_tx_q[$];
    rsp_t       exp_rsp_q[$];
    miso_t      miso_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, rsp_count = 0;
    int tready_pct = 80, rx_pct = 80, rsp_pct = 70, cmd_pct = 60;
    bit agent_en = 1, rsp_auto = 1, rsp_force = 0, drop_third = 0, abort_mode = 0;
    int slave_pos = 0;
    logic [7:0]  slave_hi = '0;
    logic [14:0] slave_addr = '0;
    logic        slave_rd = 1'b0;
    bit cmd_taken = 0, rx_taken = 0, cmd_hs_prev = 0, rsp_due = 0;
    bit frame_open = 0, prev_rsp_hold = 0, prev_rsp_valid = 0, tvalid_at_rise = 0;
    int rx_in_frame = 0;
    logic [8:0] held_rsp = '0;
    int last_hs_cyc = 0, rsp_rise_cyc = 0, rsp_hs_cyc = 0, cmd_hs_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(input logic rw, input logic [14:0] addr, input logic [7:0] wdata);
        cmd_t c;
        c.rw = rw; c.addr = addr; c.wdata = wdata;
        cmd_q.push_back(c);
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge
    task automatic cycle();
        cmd_t       c;
        rsp_t       e;
        logic [7:0] miso;
        bit         rsp_hs;
        @(negedge aclk);
        cyc++;
        if (prev_rsp_hold) begin
            check("rsp_hold_valid", rsp_valid, 1'b1);
            check("rsp_hold_data", {rsp_err, rsp_rdata}, held_rsp);
        end
        if (rsp_valid) check("cmd_ready_busy_in_rsp", {cmd_ready, busy}, 2'b01);
        if (rsp_valid && !prev_rsp_valid) begin
            rsp_rise_cyc   = cyc;
            tvalid_at_rise = m_axis_tvalid;
        end
        if (cmd_hs_prev) check("tx_first_latency", {m_axis_tvalid, busy}, 2'b11);
        if (rsp_due) check("rsp_latency", rsp_valid, 1'b1);
        if (slave_pos != 0) check("tx_gap", m_axis_tvalid, 1'b1);
        cmd_hs_prev = 0;
        rsp_due     = 0;

        // response consumer
        rsp_ready = rsp_force || (rsp_auto && ($urandom_range(99) < rsp_pct));
        rsp_hs = rsp_valid && rsp_ready;
        if (rsp_hs) begin
            rsp_hs_cyc = cyc;
            rsp_count++;
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
            else begin
                e = exp_rsp_q.pop_front();
                $display("rsp  cyc=%0d rdata=%02h err=%0d (exp %02h/%0d)", cyc, rsp_rdata, rsp_err, e.rdata, e.err);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
        prev_rsp_hold  = rsp_valid && !rsp_hs;
        held_rsp       = {rsp_err, rsp_rdata};
        prev_rsp_valid = rsp_valid;

        // SPI master + slave: MOSI byte in, MISO byte queued back on the Rx stream
        m_axis_tready = agent_en && ($urandom_range(99) < tready_pct);
        if (m_axis_tvalid && m_axis_tready) begin
            last_hs_cyc = cyc;
            if (exp_tx_q.size() == 0) check("tx_unexpected", 1'b1, 1'b0);
            else check("tx_byte", m_axis_tdata, exp_tx_q.pop_front());
            miso = 8'($urandom);
            case (slave_pos)
                0: slave_hi = m_axis_tdata;
                1: begin
                    slave_addr = {slave_hi[6:0], m_axis_tdata};
                    slave_rd   = (slave_hi[7] == RF);
                end
                default: begin
                    if (slave_rd) miso = slave_mem[slave_addr];
                    else slave_mem[slave_addr] = m_axis_tdata;
                end
            endcase
            if (!(drop_third && slave_pos == 2))
                miso_q.push_back({miso, 32'(cyc + int'($urandom_range(1, 3)))});
            slave_pos = (slave_pos == 2) ? 0 : slave_pos + 1;
        end

        // Rx stream source; a presented byte is held until taken
        if (!(s_axis_tvalid && !rx_taken)) begin
            s_axis_tvalid = 1'b0;
            if (agent_en && miso_q.size() > 0 && miso_q[0].t <= 32'(cyc) && $urandom_range(99) < rx_pct) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = miso_q[0].d;
            end
        end
        rx_taken = 0;
        if (s_axis_tvalid && s_axis_tready) begin
            void'(miso_q.pop_front());
            rx_taken    = 1;
            last_hs_cyc = cyc;
            if (frame_open) begin
                rx_in_frame++;
                if (rx_in_frame == 3) begin
                    frame_open = 0;
                    rsp_due    = 1;
                end
            end
        end

        // command source; held until accepted
        if (!(cmd_valid && !cmd_taken)) begin
            cmd_valid = 1'b0;
            if (cmd_q.size() > 0 && $urandom_range(99) < cmd_pct) begin
                cmd_valid = 1'b1;
                cmd_rw    = cmd_q[0].rw;
                cmd_addr  = cmd_q[0].addr;
                cmd_wdata = cmd_q[0].wdata;
            end
        end
        cmd_taken = 0;
        if (cmd_valid && cmd_ready) begin
            c = cmd_q.pop_front();
            cmd_taken   = 1;
            cmd_hs_prev = 1;
            cmd_hs_cyc  = cyc;
            $display("cmd  cyc=%0d rw=%0d addr=%04h wdata=%02h", cyc, c.rw, c.addr, c.wdata);
            check("one_outstanding", exp_rsp_q.size(), 0);
            frame_open  = 1;
            rx_in_frame = 0;
            exp_tx_q.push_back({(c.rw ? RF : ~RF), c.addr[14:8]});
            exp_tx_q.push_back(c.addr[7:0]);
            exp_tx_q.push_back(c.rw ? 8'h00 : c.wdata);
            if (abort_mode) begin
                e.rdata = 8'h00; e.err = 1'b1;
            end else if (c.rw) begin
                e.rdata = ref_mem[c.addr]; e.err = 1'b0;
            end else begin
                ref_mem[c.addr] = c.wdata;
                e.rdata = 8'h00; e.err = 1'b0;
            end
            exp_rsp_q.push_back(e);
        end
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_count < target && n < budget) begin
            cycle();
            n++;
        end
        if (rsp_count < target) check("rsp_wait_timeout", rsp_count, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        for (int i = 0; i < 32768; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i]   = slave_mem[i];
        end
        slave_mem[5] = 8'h5C;
        ref_mem[5]   = 8'h5C;

        // reset values
        repeat (3) @(negedge aclk);
        check("rst_ctrl", {cmd_ready, rsp_valid, rsp_err, m_axis_tvalid, busy, s_axis_tready}, 6'b000001);
        check("rst_data", {rsp_rdata, m_axis_tdata}, 16'h0000);
        aresetn = 1'b1;
        cycle();
        check("idle_cmd_ready", {cmd_ready, busy}, 2'b10);

        // directed write, then directed read
        push_cmd(1'b0, 15'h1234, 8'hA5);
        wait_rsp(1, 300);
        push_cmd(1'b1, 15'h0005, 8'hFF);
        wait_rsp(2, 300);

        // response backpressure; the next command must wait for the response handshake
        rsp_auto = 0;
        cmd_pct  = 100;
        push_cmd(1'b1, 15'h0100, 8'h00);
        n = 0;
        while (!rsp_valid && n < 300) begin cycle(); n++; end
        check("bp_rsp_seen", rsp_valid, 1'b1);
        push_cmd(1'b0, 15'h0100, 8'h77);
        repeat (20) cycle();
        check("bp_cmd_blocked", cmd_q.size(), 1);
        rsp_force = 1;
        cycle();
        rsp_force = 0;
        rsp_auto  = 1;
        n = 0;
        while (cmd_q.size() != 0 && n < 50) begin cycle(); n++; end
        check("bp_cmd_after_rsp", cmd_hs_cyc - rsp_hs_cyc, 1);
        wait_rsp(4, 300);
        cmd_pct = 60;

        // timeout: only two Rx bytes come back
        drop_third = 1;
        abort_mode = 1;
        push_cmd(1'b1, 15'h0042, 8'h00);
        wait_rsp(5, 400);
        // the abort edge is TO edges after the last handshake edge; rsp_valid is seen one sample later
        check("timeout_delay", rsp_rise_cyc - last_hs_cyc, TO + 1);
        check("timeout_tvalid", tvalid_at_rise, 1'b0);
        drop_third = 0;
        abort_mode = 0;
        push_cmd(1'b0, 15'h0042, 8'h3C);
        wait_rsp(6, 300);

        // reset mid-frame after byte1 is accepted
        push_cmd(1'b1, 15'h0777, 8'h00);
        n = 0;
        while (slave_pos != 2 && n < 300) begin cycle(); n++; end
        check("mid_reach_byte1", slave_pos, 2);
        @(negedge aclk);
        cyc++;
        aresetn = 1'b0;
        m_axis_tready = 1'b0; cmd_valid = 1'b0; s_axis_tvalid = 1'b0; rsp_ready = 1'b0;
        @(negedge aclk);
        cyc++;
        check("mid_rst_ctrl", {cmd_ready, rsp_valid, rsp_err, m_axis_tvalid, busy, s_axis_tready}, 6'b000001);
        check("mid_rst_data", {rsp_rdata, m_axis_tdata}, 16'h0000);
        aresetn = 1'b1;
        exp_tx_q.delete();
        exp_rsp_q.delete();
        slave_pos = 0; frame_open = 0; prev_rsp_hold = 0; prev_rsp_valid = 0;
        cmd_taken = 0; rx_taken = 0; cmd_hs_prev = 0; rsp_due = 0;
        base = rsp_count;
        cycle();
        check("mid_idle_cmd_ready", cmd_ready, 1'b1);
        repeat (30) cycle();
        check("mid_stray_drained", miso_q.size(), 0);
        check("mid_no_rsp", rsp_count, base);

        // random back-to-back traffic on a small address window so reads hit earlier writes
        for (int i = 0; i < 8; i++)
            push_cmd(1'($urandom), {12'h2A0, 3'($urandom)}, 8'($urandom));
        wait_rsp(base + 8, 3000);
        repeat (5) cycle();
        check("final_rsp_queue_empty", exp_rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
